// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - adder result word type and flag consistency helper
package adder_pkg;

  localparam int NBITS = 8;

  typedef struct packed {
    logic signed [NBITS-1:0] s;
    logic                    n;
    logic                    z;
    logic                    p;
  } result_t;

  // True when any flag disagrees with the sum it travels with.
  function automatic logic flags_bad(result_t r);
    return (r.n != r.s[NBITS-1]) || (r.z != (r.s == '0)) || (r.p != ~r.s[0]);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            inc,
  output logic [CNTW-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/adder_result_buffer.sv
// rtl/adder_result_buffer.sv - result FIFO with flag statistics and sticky consistency error
module adder_result_buffer
  import adder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [NBITS-1:0] in_s,
  input  logic             in_n,
  input  logic             in_z,
  input  logic             in_p,
  output logic             in_ready,
  output logic             out_valid,
  output logic [NBITS-1:0] out_s,
  output logic             out_n,
  output logic             out_z,
  output logic             out_p,
  input  logic             out_ready,
  input  logic             clr_stats,
  output logic [CNTW-1:0]  cnt_neg,
  output logic [CNTW-1:0]  cnt_zero,
  output logic [CNTW-1:0]  cnt_even,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  result_t       mem [DEPTH];
  result_t       in_word;
  result_t       head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          stat_en;

  assign in_word   = '{s: in_s, n: in_n, z: in_z, p: in_p};
  // Readiness comes from registered count only, so a same-cycle pop never frees a slot.
  assign in_ready  = !reset && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head  = mem[rd_ptr];
  assign out_s = head.s;
  assign out_n = head.n;
  assign out_z = head.z;
  assign out_p = head.p;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // A word accepted during clr_stats is stored but neither counted nor checked.
  assign stat_en = push && !clr_stats;

  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      err <= 1'b0;
    end else if (stat_en && flags_bad(in_word)) begin
      err <= 1'b1;
    end
  end

  sat_counter #(.CNTW(CNTW)) u_cnt_neg (
    .clk(clk), .reset(reset), .clr(clr_stats), .inc(stat_en && in_n), .q(cnt_neg)
  );

  sat_counter #(.CNTW(CNTW)) u_cnt_zero (
    .clk(clk), .reset(reset), .clr(clr_stats), .inc(stat_en && in_z), .q(cnt_zero)
  );

  sat_counter #(.CNTW(CNTW)) u_cnt_even (
    .clk(clk), .reset(reset), .clr(clr_stats), .inc(stat_en && in_p), .q(cnt_even)
  );

endmodule

// File: tb/tb_adder_result_buffer.sv
// tb/tb_adder_result_buffer.sv - directed bench with queue model and per-cycle compare
module tb_adder_result_buffer;

  localparam int DEPTH = 4;
  localparam int CMAX  = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_s = '0;
  logic       in_n = 1'b0;
  logic       in_z = 1'b0;
  logic       in_p = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_s;
  logic       out_n;
  logic       out_z;
  logic       out_p;
  logic       out_ready = 1'b0;
  logic       clr_stats = 1'b0;
  logic [7:0] cnt_neg;
  logic [7:0] cnt_zero;
  logic [7:0] cnt_even;
  logic       err;

  int total = 0;
  int bad = 0;
  bit started = 0;

  adder_result_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_s(in_s), .in_n(in_n),
    .in_z(in_z), .in_p(in_p), .in_ready(in_ready), .out_valid(out_valid),
    .out_s(out_s), .out_n(out_n), .out_z(out_z), .out_p(out_p),
    .out_ready(out_ready), .clr_stats(clr_stats), .cnt_neg(cnt_neg),
    .cnt_zero(cnt_zero), .cnt_even(cnt_even), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of {s,n,z,p} words plus plain integer statistics.
  logic [10:0] mq[$];
  int m_neg = 0, m_zero = 0, m_even = 0;
  bit m_err = 0;

  function automatic bit word_bad(logic [7:0] s, logic n, logic z, logic p);
    int v;
    v = int'($signed(s));
    return (n != (v < 0)) || (z != (v == 0)) || (p != (v % 2 == 0));
  endfunction

  always @(posedge clk) begin
    bit acc, take;
    if (reset) begin
      mq.delete();
      m_neg = 0; m_zero = 0; m_even = 0; m_err = 0;
    end else begin
      acc  = in_valid && (mq.size() < DEPTH);
      take = out_ready && (mq.size() > 0);
      if (take) void'(mq.pop_front());
      if (acc) mq.push_back({in_s, in_n, in_z, in_p});
      if (clr_stats) begin
        m_neg = 0; m_zero = 0; m_even = 0; m_err = 0;
      end else if (acc) begin
        if (in_n && m_neg < CMAX) m_neg++;
        if (in_z && m_zero < CMAX) m_zero++;
        if (in_p && m_even < CMAX) m_even++;
        if (word_bad(in_s, in_n, in_z, in_p)) m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", int'(in_ready), int'(!reset && mq.size() < DEPTH));
      check("out_valid", int'(out_valid), int'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("out_word", int'({out_s, out_n, out_z, out_p}), int'(mq[0]));
      end
      check("cnt_neg", int'(cnt_neg), m_neg);
      check("cnt_zero", int'(cnt_zero), m_zero);
      check("cnt_even", int'(cnt_even), m_even);
      check("err", int'(err), int'(m_err));
    end
  end

  // Drive a consistent word for the next edge.
  task automatic drive(int v);
    in_valid = 1'b1;
    in_s = 8'(v);
    in_n = (v < 0);
    in_z = (v == 0);
    in_p = (v % 2 == 0);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int exp_pop[4];
    exp_pop = '{5, -3, 0, 6};
    step(); step();
    started = 1;
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    reset = 1'b0;
    step();
    check("reset_cnt_neg", int'(cnt_neg), 0);
    check("reset_err", int'(err), 0);

    // 1: fill to full with no consumer
    foreach (exp_pop[i]) begin
      drive(exp_pop[i]);
      step();
    end
    check("full_in_ready", int'(in_ready), 0);
    check("t1_cnt_neg", int'(cnt_neg), 1);
    check("t1_cnt_zero", int'(cnt_zero), 1);
    check("t1_cnt_even", int'(cnt_even), 2);
    check("t1_out_s", int'($signed(out_s)), 5);
    drive(99);
    step();
    check("full_hold_out_s", int'($signed(out_s)), 5);
    check("full_ignored_cnt_neg", int'(cnt_neg), 1);

    // 2: drain in order
    in_valid = 1'b0;
    out_ready = 1'b1;
    foreach (exp_pop[i]) begin
      check("drain_valid", int'(out_valid), 1);
      check("drain_s", int'($signed(out_s)), exp_pop[i]);
      step();
    end
    check("drained_out_valid", int'(out_valid), 0);

    // 3: hold at two entries with simultaneous push/pop, pointers wrap
    out_ready = 1'b0;
    drive(10); step();
    drive(11); step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("pp_head", int'($signed(out_s)), 10 + i);
      drive(12 + i);
      step();
    end
    in_valid = 1'b0;
    check("pp_tail0", int'($signed(out_s)), 20);
    step();
    check("pp_tail1", int'($signed(out_s)), 21);
    step();
    check("pp_empty", int'(out_valid), 0);

    // 4: inconsistent flags set sticky err, clr_stats clears it
    in_valid = 1'b1; in_s = 8'h04; in_n = 1'b1; in_z = 1'b0; in_p = 1'b1;
    step();
    check("err_set", int'(err), 1);
    drive(-7); step();
    drive(0); step();
    check("err_sticky", int'(err), 1);
    drive(3);
    in_n = 1'b1;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    in_valid = 1'b0;
    check("clr_err", int'(err), 0);
    check("clr_cnt_neg", int'(cnt_neg), 0);
    check("clr_cnt_even", int'(cnt_even), 0);
    check("clr_stored_s", int'($signed(out_s)), 3);

    // 5: saturation with 300 pushes of -2
    for (int i = 0; i < 300; i++) begin
      drive(-2);
      step();
    end
    in_valid = 1'b0;
    check("sat_cnt_neg", int'(cnt_neg), 255);
    check("sat_cnt_even", int'(cnt_even), 255);
    check("sat_cnt_zero", int'(cnt_zero), 0);
    check("sat_err", int'(err), 0);

    // 6: reset with three stored entries and a pending push
    step(); step(); step(); step();
    out_ready = 1'b0;
    drive(1); step();
    drive(2); step();
    drive(-4); step();
    check("pre_reset_valid", int'(out_valid), 1);
    reset = 1'b1;
    step();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_cnt_neg", int'(cnt_neg), 0);
    check("rst_cnt_even", int'(cnt_even), 0);
    check("rst_err", int'(err), 0);
    check("rst_in_ready", int'(in_ready), 0);
    reset = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);

    started = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
